// File: rtl/wifi_tx_pilot_inserter_pkg.sv
// -----------------------------------------------------------------------------
// wifi_tx_pilot_inserter_pkg
// Shared constants and types for the TX pilot inserter: sample width default,
// FFT/data sizes, pilot indices, the null-subcarrier band, the pilot polarity
// LFSR seed/taps and the read FSM state type.
// Optional feature macro (consumed elsewhere): WIFI_TX_PILOT_POLARITY_EN.
// -----------------------------------------------------------------------------
package wifi_tx_pilot_inserter_pkg;

  // Default sample width (same scale as the 16QAM mapper output).
  localparam int DW_DEFAULT = 12;

  // Symbol geometry.
  localparam int N_FFT  = 64;
  localparam int N_DATA = 48;

  // Pilot IFFT indices; PILOT_IDX_1 (21) carries the inverted pilot.
  localparam logic [5:0] PILOT_IDX_0 = 6'd7;
  localparam logic [5:0] PILOT_IDX_1 = 6'd21;
  localparam logic [5:0] PILOT_IDX_2 = 6'd43;
  localparam logic [5:0] PILOT_IDX_3 = 6'd57;

  // Null band (DC at index 0 is handled separately).
  localparam logic [5:0] NULL_LO = 6'd27;
  localparam logic [5:0] NULL_HI = 6'd37;

  // Pilot polarity LFSR x^7 + x^4 + 1, all-ones seed.
  localparam int         LFSR_W      = 7;
  localparam int         LFSR_TAP_HI = 7;
  localparam int         LFSR_TAP_LO = 4;
  localparam logic [6:0] LFSR_SEED   = 7'h7F;

  // Read-side FSM states.
  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_EMIT = 1'b1
  } rd_state_e;

endpackage

// File: rtl/wifi_tx_pilot_polarity_gen.sv
// -----------------------------------------------------------------------------
// wifi_tx_pilot_polarity_gen
// Produces the per-symbol pilot polarity. With WIFI_TX_PILOT_POLARITY_EN
// defined, a 7-bit LFSR (x^7 + x^4 + 1, seeded all-ones) supplies one bit per
// symbol: 0 -> p=+1, 1 -> p=-1. Without the macro p is always +1 and no LFSR
// is built.
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset (reseeds the LFSR)
//   step_i     advance to the next symbol's polarity
//   restart_i  synchronous reseed (takes priority over step_i)
//   p_neg_o    1 when the current symbol's pilots are inverted
// -----------------------------------------------------------------------------
module wifi_tx_pilot_polarity_gen
  import wifi_tx_pilot_inserter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic step_i,
  input  logic restart_i,
  output logic p_neg_o
);

`ifdef WIFI_TX_PILOT_POLARITY_EN
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic              fb;

  // The feedback bit is also the polarity bit of the current symbol.
  assign fb      = lfsr_q[LFSR_TAP_HI-1] ^ lfsr_q[LFSR_TAP_LO-1];
  assign p_neg_o = fb;

  always_comb begin
    lfsr_d = lfsr_q;
    if (restart_i) begin
      lfsr_d = LFSR_SEED;
    end else if (step_i) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{clk_i, rst_ni, step_i, restart_i};
  assign p_neg_o   = 1'b0;
`endif

endmodule

// File: rtl/wifi_tx_pilot_inserter.sv
// -----------------------------------------------------------------------------
// wifi_tx_pilot_inserter
// Collects 48 mapped data subcarriers per OFDM symbol into ping-pong banks and
// emits 64 subcarrier values per symbol in IFFT index order, inserting four
// BPSK pilots (7, 43, 57 at +p, 21 at -p) and zeroing DC and the 27..37 band.
// Pilot polarity p comes from wifi_tx_pilot_polarity_gen; define
// WIFI_TX_PILOT_POLARITY_EN for the LFSR sequence, otherwise p = +1.
//
// Handshake: a sample is taken on a rising edge where valid_in && ready_in.
// ready_in is low exactly while the current write bank is full; a valid_in
// while ready_in is low is dropped and sets the sticky overflow flag.
// valid_out is a pure strobe (no back-pressure from the IFFT side).
//
// Ports:
//   clk                          clock, rising edge
//   reset                        asynchronous active-low reset
//   sym_restart                  synchronous packet restart (sample in the same
//                                cycle is accepted as d=0)
//   valid_in, data_in_real/imag  mapper samples (DW-bit two's complement)
//   ready_in                     write bank can accept
//   valid_out, data_out_real/imag, sym_start   registered IFFT-order output
//   overflow                     sticky drop flag
//   dbg_state_o                  read FSM state
// -----------------------------------------------------------------------------
module wifi_tx_pilot_inserter
  import wifi_tx_pilot_inserter_pkg::*;
#(
  parameter int DW        = DW_DEFAULT,
  parameter int PILOT_AMP = 512
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sym_restart,
  input  logic          valid_in,
  input  logic [DW-1:0] data_in_real,
  input  logic [DW-1:0] data_in_imag,
  output logic          ready_in,
  output logic          valid_out,
  output logic [DW-1:0] data_out_real,
  output logic [DW-1:0] data_out_imag,
  output logic          sym_start,
  output logic          overflow,
  output rd_state_e     dbg_state_o
);

  localparam logic [5:0]    LAST_IDX = 6'(N_FFT - 1);
  localparam logic [5:0]    LAST_D   = 6'(N_DATA - 1);
  localparam logic [DW-1:0] AMP_POS  = DW'(PILOT_AMP);
  localparam logic [DW-1:0] AMP_NEG  = DW'(-PILOT_AMP);

  // Sample buffers, two banks of 48; contents need no reset.
  logic [DW-1:0] mem_re_q [2][N_DATA];
  logic [DW-1:0] mem_im_q [2][N_DATA];

  // Write side.
  logic [5:0] wr_cnt_q, wr_cnt_d;
  logic       wr_bank_q, wr_bank_d;
  logic [1:0] full_q, full_d;
  logic       overflow_q, overflow_d;
  logic       ready_int;
  logic       accept;
  logic       wr_sel_bank;
  logic [5:0] wr_addr;
  logic [1:0] set_vec, clr_vec;

  // Read side.
  rd_state_e  state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic       rd_bank_q, rd_bank_d;

  // Index decode.
  logic       is_null, is_pilot, pilot_inv;
  logic [5:0] rd_addr;

  // Output register.
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_re_q, out_re_d;
  logic [DW-1:0] out_im_q, out_im_d;
  logic          sym_start_q, sym_start_d;

  // Pilot polarity.
  logic p_neg;
  logic pol_step;

  assign ready_int = ~full_q[wr_bank_q];

  // ---------------------------------------------------------------------------
  // Write counter, bank flags and read FSM next state.
  // A bank completing its fill sets its flag in the same cycle the reader may
  // release the other bank; set and clear are applied together.
  // ---------------------------------------------------------------------------
  always_comb begin
    accept      = 1'b0;
    wr_sel_bank = wr_bank_q;
    wr_addr     = wr_cnt_q;
    set_vec     = 2'b00;
    clr_vec     = 2'b00;
    wr_cnt_d    = wr_cnt_q;
    wr_bank_d   = wr_bank_q;
    full_d      = full_q;
    overflow_d  = overflow_q;
    state_d     = state_q;
    idx_d       = idx_q;
    rd_bank_d   = rd_bank_q;

    if (sym_restart) begin
      // Both bank pointers return to 0 so writer and reader stay aligned.
      accept      = valid_in;
      wr_sel_bank = 1'b0;
      wr_addr     = 6'd0;
      wr_cnt_d    = valid_in ? 6'd1 : 6'd0;
      wr_bank_d   = 1'b0;
      full_d      = 2'b00;
      overflow_d  = 1'b0;
      state_d     = RD_IDLE;
      idx_d       = 6'd0;
      rd_bank_d   = 1'b0;
    end else begin
      accept = valid_in && ready_int;
      if (valid_in && !ready_int) begin
        overflow_d = 1'b1;
      end
      if (accept) begin
        if (wr_cnt_q == LAST_D) begin
          wr_cnt_d         = 6'd0;
          wr_bank_d        = ~wr_bank_q;
          set_vec[wr_bank_q] = 1'b1;
        end else begin
          wr_cnt_d = wr_cnt_q + 6'd1;
        end
      end

      case (state_q)
        RD_IDLE: begin
          if (full_q[rd_bank_q]) begin
            state_d = RD_EMIT;
            idx_d   = 6'd0;
          end
        end
        RD_EMIT: begin
          idx_d = idx_q + 6'd1;
          if (idx_q == LAST_IDX) begin
            clr_vec[rd_bank_q] = 1'b1;
            rd_bank_d          = ~rd_bank_q;
            // Include a fill finishing this very cycle so symbols stay gapless.
            if (full_q[~rd_bank_q] || set_vec[~rd_bank_q]) begin
              state_d = RD_EMIT;
            end else begin
              state_d = RD_IDLE;
            end
          end
        end
        default: state_d = RD_IDLE;
      endcase

      full_d = (full_q | set_vec) & ~clr_vec;
    end
  end

  // ---------------------------------------------------------------------------
  // IFFT index -> null / pilot / buffer address.
  // ---------------------------------------------------------------------------
  always_comb begin
    is_null   = 1'b0;
    is_pilot  = 1'b0;
    pilot_inv = 1'b0;
    rd_addr   = 6'd0;
    if (idx_q == 6'd0 || (idx_q >= NULL_LO && idx_q <= NULL_HI)) begin
      is_null = 1'b1;
    end else if (idx_q == PILOT_IDX_0 || idx_q == PILOT_IDX_2 ||
                 idx_q == PILOT_IDX_3) begin
      is_pilot = 1'b1;
    end else if (idx_q == PILOT_IDX_1) begin
      is_pilot  = 1'b1;
      pilot_inv = 1'b1;
    end else if (idx_q <= 6'd6) begin
      rd_addr = idx_q + 6'd23;
    end else if (idx_q <= 6'd20) begin
      rd_addr = idx_q + 6'd22;
    end else if (idx_q <= 6'd26) begin
      rd_addr = idx_q + 6'd21;
    end else if (idx_q <= 6'd42) begin
      rd_addr = idx_q - 6'd38;
    end else if (idx_q <= 6'd56) begin
      rd_addr = idx_q - 6'd39;
    end else begin
      rd_addr = idx_q - 6'd40;
    end
  end

  // Output next state; a restart aborts the current symbol immediately.
  always_comb begin
    out_valid_d = 1'b0;
    out_re_d    = '0;
    out_im_d    = '0;
    sym_start_d = 1'b0;
    if (state_q == RD_EMIT && !sym_restart) begin
      out_valid_d = 1'b1;
      sym_start_d = (idx_q == 6'd0);
      if (is_null) begin
        out_re_d = '0;
        out_im_d = '0;
      end else if (is_pilot) begin
        out_re_d = (p_neg ^ pilot_inv) ? AMP_NEG : AMP_POS;
        out_im_d = '0;
      end else begin
        out_re_d = mem_re_q[rd_bank_q][rd_addr];
        out_im_d = mem_im_q[rd_bank_q][rd_addr];
      end
    end
  end

  // Polarity advances after the last index of each emitted symbol.
  assign pol_step = (state_q == RD_EMIT) && (idx_q == LAST_IDX) && !sym_restart;

  wifi_tx_pilot_polarity_gen u_pol (
    .clk_i     (clk),
    .rst_ni    (reset),
    .step_i    (pol_step),
    .restart_i (sym_restart),
    .p_neg_o   (p_neg)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_re_q[wr_sel_bank][wr_addr] <= data_in_real;
      mem_im_q[wr_sel_bank][wr_addr] <= data_in_imag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt_q    <= 6'd0;
      wr_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      overflow_q  <= 1'b0;
      state_q     <= RD_IDLE;
      idx_q       <= 6'd0;
      rd_bank_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      sym_start_q <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      rd_bank_q   <= rd_bank_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      sym_start_q <= sym_start_d;
    end
  end

  assign ready_in      = ready_int;
  assign valid_out     = out_valid_q;
  assign data_out_real = out_re_q;
  assign data_out_imag = out_im_q;
  assign sym_start     = sym_start_q;
  assign overflow      = overflow_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_wifi_tx_pilot_inserter.sv
// -----------------------------------------------------------------------------
// tb_wifi_tx_pilot_inserter
// Directed bench for the pilot inserter. The expected symbol layout is derived
// from logical subcarriers k = -26..26 (data numbered in increasing k, pilots
// at k = -21, -7, +7 (+p) and +21 (-p), i = k mod 64).
// -----------------------------------------------------------------------------
module tb_wifi_tx_pilot_inserter;
  import wifi_tx_pilot_inserter_pkg::*;

  localparam int DW  = 12;
  localparam int AMP = 512;
  localparam int EW  = 1 + 2 * DW;

  logic          clk;
  logic          reset;
  logic          sym_restart;
  logic          valid_in;
  logic [DW-1:0] data_in_real;
  logic [DW-1:0] data_in_imag;
  logic          ready_in;
  logic          valid_out;
  logic [DW-1:0] data_out_real;
  logic [DW-1:0] data_out_imag;
  logic          sym_start;
  logic          overflow;
  rd_state_e     dbg_state;

  int checks;
  int errors;
  logic [EW-1:0] exp_q[$];

  int map_d[64];   // >=0 data address, -1 null, -2 pilot +p, -3 pilot -p
  int cur_re[48];
  int cur_im[48];
  int wr_n;
  int sym_k;
  bit saw_not_ready;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  wifi_tx_pilot_inserter #(.DW(DW), .PILOT_AMP(AMP)) dut (
    .clk           (clk),
    .reset         (reset),
    .sym_restart   (sym_restart),
    .valid_in      (valid_in),
    .data_in_real  (data_in_real),
    .data_in_imag  (data_in_imag),
    .ready_in      (ready_in),
    .valid_out     (valid_out),
    .data_out_real (data_out_real),
    .data_out_imag (data_out_imag),
    .sym_start     (sym_start),
    .overflow      (overflow),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- model helpers ----------------
  function automatic bit p_neg_of(input int k);
`ifdef WIFI_TX_PILOT_POLARITY_EN
    // bit k = polarity of symbol k: +,+,+,+,-,-,-,+,-,-,-,-,+,+,-,+
    logic [15:0] seq;
    seq = 16'b0100_1111_0111_0000;
    return seq[k % 16];
`else
    return (k < 0);
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_symbol();
    bit pn;
    int re;
    int im;
    logic [DW-1:0] re_v;
    logic [DW-1:0] im_v;
    pn = p_neg_of(sym_k);
    sym_k++;
    for (int i = 0; i < 64; i++) begin
      re = 0;
      im = 0;
      if (map_d[i] == -2) re = pn ? -AMP : AMP;
      else if (map_d[i] == -3) re = pn ? AMP : -AMP;
      else if (map_d[i] >= 0) begin
        re = cur_re[map_d[i]];
        im = cur_im[map_d[i]];
      end
      re_v = re[DW-1:0];
      im_v = im[DW-1:0];
      exp_q.push_back({(i == 0), re_v, im_v});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input int re, input int im);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ready_in && guard < 500) begin
      saw_not_ready = 1'b1;
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      check("send_ready_timeout", 0, 1);
    end else begin
      valid_in     = 1'b1;
      data_in_real = re[DW-1:0];
      data_in_imag = im[DW-1:0];
      @(posedge clk);
      #1 valid_in = 1'b0;
      cur_re[wr_n] = re;
      cur_im[wr_n] = im;
      wr_n++;
      if (wr_n == 48) begin
        push_symbol();
        wr_n = 0;
      end
    end
  endtask

  task automatic drop(input int n);
    int junk;
    junk = 777;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      check("ready_low_on_drop", int'(ready_in), 0);
      valid_in     = 1'b1;
      data_in_real = junk[DW-1:0];
      data_in_imag = junk[DW-1:0];
      @(posedge clk);
      #1 valid_in = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check(name, exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_sym_start(output bit ok);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!sym_start && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    ok = (guard < 500);
    if (!ok) check("sym_start_timeout", 0, 1);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    a = {sym_start, data_out_real, data_out_imag};
    if (valid_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got ss=%0b re=%0d im=%0d with nothing expected (t=%0t)",
                 sym_start, $signed(data_out_real), $signed(data_out_imag), $time);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL sample: got ss=%0b re=%0d im=%0d expected ss=%0b re=%0d im=%0d (t=%0t)",
                   a[EW-1], $signed(a[2*DW-1:DW]), $signed(a[DW-1:0]),
                   e[EW-1], $signed(e[2*DW-1:DW]), $signed(e[DW-1:0]), $time);
        end
      end
    end else begin
      checks++;
      if (a !== '0) begin
        errors++;
        $display("FAIL idle_outputs: got ss=%0b re=%0d im=%0d expected all 0 (t=%0t)",
                 sym_start, $signed(data_out_real), $signed(data_out_imag), $time);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int d;
    checks        = 0;
    errors        = 0;
    wr_n          = 0;
    sym_k         = 0;
    saw_not_ready = 1'b0;
    reset         = 1'b0;
    sym_restart   = 1'b0;
    valid_in      = 1'b0;
    data_in_real  = '0;
    data_in_imag  = '0;

    for (int i = 0; i < 64; i++) map_d[i] = -1;
    d = 0;
    for (int k = -26; k <= 26; k++) begin
      if (k != 0) begin
        if (k == -21 || k == -7 || k == 7) map_d[(k + 64) % 64] = -2;
        else if (k == 21) map_d[(k + 64) % 64] = -3;
        else begin
          map_d[(k + 64) % 64] = d;
          d++;
        end
      end
    end

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready_in", int'(ready_in), 1);
    check("rst_overflow", int'(overflow), 0);
    check("rst_valid_out", int'(valid_out), 0);
    check("rst_state", int'(dbg_state), int'(RD_IDLE));
    reset = 1'b1;

    // 1: one symbol, data d / -d, first-symbol latency.
    for (int n = 0; n < 48; n++) send(n, -n);
    @(posedge clk);
    #1 check("latency_edge1_valid", int'(valid_out), 0);
    @(posedge clk);
    #1 check("latency_edge2_valid", int'(valid_out), 1);
    check("latency_edge2_sym_start", int'(sym_start), 1);
    wait_drain("drain_single");

    // 2: 192 continuous samples, four gapless symbols.
    saw_not_ready = 1'b0;
    fork
      begin
        for (int n = 0; n < 192; n++) send(n * 3 - 300, 1000 - n * 5);
      end
      begin
        int g;
        int gaps;
        g    = 0;
        gaps = 0;
        @(negedge clk);
        while (!valid_out && g < 500) begin
          @(negedge clk);
          g++;
        end
        for (int j = 0; j < 256; j++) begin
          if (!valid_out) gaps++;
          @(negedge clk);
        end
        check("stream_gaps", gaps, 0);
      end
    join
    check("stream_ready_dropped", int'(saw_not_ready), 1);
    check("stream_no_overflow", int'(overflow), 0);
    wait_drain("drain_stream");

    // 3: overflow while both banks are full.
    for (int n = 0; n < 96; n++) send(50 + n, -50 - n);
    drop(3);
    @(negedge clk);
    check("overflow_set", int'(overflow), 1);
    for (int n = 0; n < 48; n++) send(-400 + n * 2, 300 - n);
    wait_drain("drain_overflow");
    check("overflow_sticky", int'(overflow), 1);

    // 4: sym_restart at output index 30.
    for (int n = 0; n < 48; n++) send(200 - n, n * 4);
    wait_sym_start(ok);
    if (ok) begin
      repeat (30) @(negedge clk);
      #1;
      exp_q.delete();
      sym_restart  = 1'b1;
      valid_in     = 1'b1;
      data_in_real = 12'd100;
      data_in_imag = -12'sd100;
      @(posedge clk);
      #1;
      sym_restart = 1'b0;
      valid_in    = 1'b0;
      cur_re[0]   = 100;
      cur_im[0]   = -100;
      wr_n        = 1;
      sym_k       = 0;
      @(negedge clk);
      check("restart_valid_out", int'(valid_out), 0);
      check("restart_overflow_clr", int'(overflow), 0);
      for (int n = 1; n < 48; n++) send(n * 11 - 250, 7 - n);
      wait_drain("drain_restart");
    end

    // 5: asynchronous reset at output index 30 with a partly filled bank.
    fork
      begin
        for (int n = 0; n < 58; n++) send(n - 20, 20 - n);
      end
      begin
        wait_sym_start(ok);
        if (ok) begin
          repeat (30) @(negedge clk);
          #1;
          exp_q.delete();
          reset = 1'b0;
          #1;
          check("areset_valid_out", int'(valid_out), 0);
          check("areset_sym_start", int'(sym_start), 0);
          check("areset_data_re", int'(data_out_real), 0);
          check("areset_ready_in", int'(ready_in), 1);
          check("areset_state", int'(dbg_state), int'(RD_IDLE));
          repeat (2) @(negedge clk);
          reset = 1'b1;
        end
      end
    join
    wr_n  = 0;
    sym_k = 0;
    repeat (10) @(negedge clk);
    for (int n = 0; n < 48; n++) send(600 - n * 9, n * 13 - 300);
    wait_drain("drain_after_reset");

    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wifi_tx_pilot_inserter.md
WIFI_TX_PILOT_INSERTER -- requirements
Module: WIFI_TX_pilot_inserter

Interface
REQ-001 SHALL have parameter DW, default 12: sample width, two's complement, same scale as the 16QAM mapper output.
REQ-002 SHALL have parameter PILOT_AMP, default 512: pilot magnitude (unit amplitude; 16QAM levels are ±162/±486).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 sym_restart  input  1  synchronous packet restart pulse.
REQ-006 valid_in  input  1  data sample strobe from the mapper.
REQ-007 data_in_real / data_in_imag  input  DW each  mapped data subcarrier value.
REQ-008 ready_in  output  1  high when a sample can be accepted.
REQ-009 valid_out  output  1  output sample strobe toward the IFFT.
REQ-010 data_out_real / data_out_imag  output  DW each  subcarrier value in IFFT index order.
REQ-011 sym_start  output  1  high with IFFT index 0 of each symbol.
REQ-012 overflow  output  1  sticky: a sample was dropped.

Function
REQ-013 SHALL buffer input in two 48-entry ping-pong banks; write address d = 0..47 in arrival order; the bank is marked full and the banks swap after d=47.
REQ-014 ready_in SHALL be low exactly while the current write bank is full; valid_in with ready_in low SHALL drop the sample and set overflow.
REQ-015 Read FSM SHALL have states IDLE and EMIT; IDLE->EMIT when the read bank is full; EMIT lasts exactly 64 cycles (index i=0..63); at i=63 it SHALL clear that bank's full flag, swap the read bank, and go to EMIT again without a gap if the other bank is full, else to IDLE.
REQ-016 Output SHALL be registered; index 0 SHALL appear on the second rising edge after the edge accepting sample d=47 (when the read side is idle).
REQ-017 Null indices 0 and 27..37 SHALL output 0+0j.
REQ-018 Data mapping SHALL be: i=1..6 -> d=i+23; 8..20 -> d=i+22; 22..26 -> d=i+21; 38..42 -> d=i-38; 44..56 -> d=i-39; 58..63 -> d=i-40.
REQ-019 Pilots SHALL be real, with imag=0: i=7, 43, 57 -> +p*PILOT_AMP; i=21 -> -p*PILOT_AMP; p = ±1 per REQ-027.
REQ-020 valid_out SHALL be high for all 64 EMIT cycles; outputs SHALL be 0 and sym_start low when valid_out is low.
REQ-021 A bank that completes filling during EMIT of the other bank SHALL be queued; flag set/clear in the same cycle SHALL both take effect.
REQ-022 sym_restart SHALL clear the write counter, both full flags, and overflow; abort EMIT (outputs 0 next cycle); reset pilot index to 0; the sample presented in the same cycle SHALL be accepted as d=0.

Reset
REQ-023 Reset low SHALL asynchronously force valid_out=0, data_out_*=0, sym_start=0, overflow=0, ready_in=1, FSM=IDLE, both counters and flags cleared, and pilot LFSR to all-ones.
REQ-024 Reset asserted mid-symbol SHALL discard all buffered data; no partial symbol is emitted after release.
REQ-025 Buffer RAM contents SHALL need no reset.

Configuration
REQ-026 Macro WIFI_TX_PILOT_POLARITY_EN SHALL select pilot polarity generation.
REQ-027 Defined: p comes from the LFSR x^7+x^4+1 with an all-ones seed; LFSR bit 0 -> p=+1, bit 1 -> p=-1 (sequence +1,+1,+1,+1,-1,-1,-1,+1,...); the LFSR steps once per emitted symbol at i=63 and repeats with period 127. Undefined: p=+1 always, and no LFSR exists.

Structure
REQ-028 Shared include/package SHALL hold DW, N_FFT=64, N_DATA=48, the pilot indices {7,21,43,57}, the null range, and the LFSR seed/taps.
REQ-029 Pilot polarity SHALL be the sub-module WIFI_TX_pilot_polarity_gen (step, restart -> p); the index-to-address mapping stays inline.

Verification
REQ-030 Reset, then 48 samples d=0..47 with data_in_real=d, data_in_imag=-d -> after 2 cycles, 64 valid_out cycles; i=1 gives 24/-24, i=38 gives 0/0, i=0 and i=27..37 give 0, sym_start only at i=0.
REQ-031 With the macro, 5 symbols -> i=7 real = +512, +512, +512, +512, -512 in turn; i=21 is the negation; without the macro, always +512 / -512.
REQ-032 Continuous valid_in over 192 samples -> 4 symbols back-to-back with no valid_out gap; ready_in drops when both banks are full; overflow stays 0 while valid_in honours ready_in.
REQ-033 Drive valid_in while ready_in=0 -> sample dropped, overflow=1 until sym_restart, and the next symbol's contents are unaffected.
REQ-034 Reset or sym_restart at i=30 of EMIT -> outputs 0 next cycle; 48 fresh samples yield a clean symbol with pilot p=+1 (index 0).
